// File: rtl/serial_adder.sv
// serial_adder: bit-serial A+B+Cin adder, one sum bit per clock LSB first, valid/ready on both sides.
// Optional feature macro SERIAL_ADDER_SUB_EN adds sub_i for A-B (B inverted, carry preset to 1).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub_i,
`endif
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [CW-1:0]    cnt;
    logic             carry, carry_msb;
    logic             accept, last, sub, s, carry_nxt;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub = sub_i;
`else
    assign sub = 1'b0;
`endif

    assign accept    = valid_i && ready_o;
    assign last      = cnt == CW'(WIDTH - 1);
    assign s         = a_q[0] ^ b_q[0] ^ carry;
    assign carry_nxt = (a_q[0] & b_q[0]) | (carry & (a_q[0] ^ b_q[0]));

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state: accept -> RUN, last bit -> DONE, result taken -> IDLE
    always_comb begin
        state_nxt = (state == IDLE && accept)  ? RUN  :
                    (state == RUN  && last)    ? DONE :
                    (state == DONE && ready_i) ? IDLE : state;
    end

    // handshake outputs decoded from registered state
    always_comb begin
        ready_o = state == IDLE;
        valid_o = state == DONE;
    end

    // datapath: load operands on accept, then one full-adder step per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            carry_msb <= 1'b0;
        end else if (state == IDLE && accept) begin
            a_q   <= a_i;
            b_q   <= sub ? ~b_i : b_i;
            carry <= sub ? 1'b1 : cin_i;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            sum_q <= {s, sum_q[WIDTH-1:1]};
            carry <= carry_nxt;
            cnt   <= cnt + 1'b1;
            if (last) carry_msb <= carry;
        end
    end

    // carry register holds the final carry once RUN completes
    assign sum_o  = sum_q;
    assign cout_o = carry;
    assign ovf_o  = carry_msb ^ carry;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table vectors, hand sequences and random/exhaustive runs over WIDTH 8, 4, 2 and 64.
module tb_serial_adder;
    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        o;
    } exp_t;

    typedef struct {
        logic [7:0] a, b;
        logic       ci;
        logic [7:0] s;
        logic       c, o;
    } vec_t;

    logic        clk = 0, rst_n = 0;
    logic [63:0] a = '0, b = '0;
    logic        cin = 0, sub = 0;
    logic [3:0]  v_i = '0, r_i = '0, rdy_o, vo, co, ov;
    logic [7:0]  s8;
    logic [3:0]  s4;
    logic [1:0]  s2;
    logic [63:0] s64;
    int          wd[4] = '{8, 4, 2, 64};
    int          errors = 0, checks = 0;
    exp_t        q[$];
    vec_t        tv[6];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .valid_i(v_i[0]), .ready_o(rdy_o[0]), .a_i(a[7:0]), .b_i(b[7:0]),
        .cin_i(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub_i(sub),
`endif
        .valid_o(vo[0]), .ready_i(r_i[0]), .sum_o(s8), .cout_o(co[0]), .ovf_o(ov[0]));

    serial_adder #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .valid_i(v_i[1]), .ready_o(rdy_o[1]), .a_i(a[3:0]), .b_i(b[3:0]),
        .cin_i(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub_i(sub),
`endif
        .valid_o(vo[1]), .ready_i(r_i[1]), .sum_o(s4), .cout_o(co[1]), .ovf_o(ov[1]));

    serial_adder #(.WIDTH(2)) u2 (
        .clk(clk), .rst_n(rst_n), .valid_i(v_i[2]), .ready_o(rdy_o[2]), .a_i(a[1:0]), .b_i(b[1:0]),
        .cin_i(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub_i(sub),
`endif
        .valid_o(vo[2]), .ready_i(r_i[2]), .sum_o(s2), .cout_o(co[2]), .ovf_o(ov[2]));

    serial_adder #(.WIDTH(64)) u64 (
        .clk(clk), .rst_n(rst_n), .valid_i(v_i[3]), .ready_o(rdy_o[3]), .a_i(a), .b_i(b),
        .cin_i(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub_i(sub),
`endif
        .valid_o(vo[3]), .ready_i(r_i[3]), .sum_o(s64), .cout_o(co[3]), .ovf_o(ov[3]));

    function automatic logic [63:0] sget(int k);
        return k == 0 ? 64'(s8) : k == 1 ? 64'(s4) : k == 2 ? 64'(s2) : s64;
    endfunction

    function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endfunction

    // reference: wide addition, signed overflow from operand/result sign bits
    function automatic void model(int w, logic [63:0] x, logic [63:0] y, logic ci,
                                  output logic [63:0] s, output logic c, output logic o);
        logic [63:0] m;
        logic [64:0] f;
        m = (w == 64) ? '1 : (64'd1 << w) - 1;
        x = x & m;
        y = y & m;
        f = {1'b0, x} + {1'b0, y} + 65'(ci);
        s = f[63:0] & m;
        c = f[w];
        o = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
    endfunction

    task automatic run(int k, logic [63:0] x, logic [63:0] y, logic ci, logic sb,
                       logic [63:0] es, logic ec, logic eo, int stall, bit poke);
        exp_t e;
        int   lat;
        a = x; b = y; cin = ci; sub = sb;
        v_i[k] = 1;
        r_i[k] = (stall == 0);
        lat = 0;
        while (!rdy_o[k] && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        chk("accept_ready", 64'(rdy_o[k]), 64'd1);
        @(posedge clk); #1;
        v_i[k] = 0;
        q.push_back('{es, ec, eo});
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
            if (poke && lat == 3) begin
                a = ~x; b = x; v_i[k] = 1;
            end
        end while (!vo[k] && lat < 200);
        chk("latency", 64'(lat), 64'(wd[k]));
        if (!vo[k]) return;
        e = q.pop_front();
        chk("sum", sget(k), e.s);
        chk("cout", 64'(co[k]), 64'(e.c));
        chk("ovf", 64'(ov[k]), 64'(e.o));
        repeat (stall) begin
            @(posedge clk); #1;
            chk("stall_sum", sget(k), e.s);
            chk("stall_cout", 64'(co[k]), 64'(e.c));
            chk("stall_valid", 64'(vo[k]), 64'd1);
            chk("stall_ready", 64'(rdy_o[k]), 64'd0);
        end
        r_i[k] = 1;
        @(posedge clk); #1;
        r_i[k] = 0;
        chk("post_ready", 64'(rdy_o[k]), 64'd1);
        chk("post_valid", 64'(vo[k]), 64'd0);
        if (poke) begin
            v_i[k] = 0;
            @(posedge clk); #1;
            chk("no_accept", 64'(rdy_o[k]), 64'd1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] es, x, y;
        logic        ec, eo, ci;
        tv[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        tv[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tv[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tv[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tv[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tv[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rst_ready", 64'(rdy_o[k]), 64'd1);
            chk("rst_valid", 64'(vo[k]), 64'd0);
            chk("rst_sum", sget(k), 64'd0);
            chk("rst_cout", 64'(co[k]), 64'd0);
            chk("rst_ovf", 64'(ov[k]), 64'd0);
        end
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++)
            run(0, 64'(tv[i].a), 64'(tv[i].b), tv[i].ci, 1'b0, 64'(tv[i].s), tv[i].c, tv[i].o, 0, 0);
        run(0, 64'h12, 64'h34, 1'b0, 1'b0, 64'h46, 1'b0, 1'b0, 5, 1);
        a = 64'hAA; b = 64'h55; cin = 0; v_i[0] = 1;
        @(posedge clk); #1;
        v_i[0] = 0;
        q.push_back('{64'hFF, 1'b0, 1'b0});
        repeat (3) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        q.delete();
        chk("mid_rst_valid", 64'(vo[0]), 64'd0);
        chk("mid_rst_ready", 64'(rdy_o[0]), 64'd1);
        chk("mid_rst_sum", sget(0), 64'd0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        run(0, 64'h01, 64'h02, 1'b0, 1'b0, 64'h03, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 512; i++) begin
            x = 64'(i[3:0]); y = 64'(i[7:4]); ci = i[8];
            model(4, x, y, ci, es, ec, eo);
            run(1, x, y, ci, 1'b0, es, ec, eo, 0, 0);
        end
        for (int i = 0; i < 20; i++) begin
            x = 64'($urandom_range(0, 3)); y = 64'($urandom_range(0, 3)); ci = 1'($urandom);
            model(2, x, y, ci, es, ec, eo);
            run(2, x, y, ci, 1'b0, es, ec, eo, i % 3, 0);
        end
        for (int i = 0; i < 20; i++) begin
            x = {$urandom, $urandom}; y = {$urandom, $urandom}; ci = 1'($urandom);
            if (i == 0) begin x = '1; y = 64'd1; end
            if (i == 1) begin x = 64'h7FFF_FFFF_FFFF_FFFF; y = 64'd1; ci = 0; end
            model(64, x, y, ci, es, ec, eo);
            run(3, x, y, ci, 1'b0, es, ec, eo, 0, 0);
        end
`ifdef SERIAL_ADDER_SUB_EN
        run(0, 64'h10, 64'h20, 1'b1, 1'b1, 64'hF0, 1'b0, 1'b0, 0, 0);
        run(0, 64'h80, 64'h01, 1'b0, 1'b1, 64'h7F, 1'b1, 1'b1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            x = 64'($urandom_range(0, 255)); y = 64'($urandom_range(0, 255)); ci = 1'($urandom);
            model(8, x, ~y, 1'b1, es, ec, eo);
            run(0, x, y, ci, 1'b1, es, ec, eo, 0, 0);
        end
        x = 64'h33; y = 64'h44;
        model(8, x, y, 1'b1, es, ec, eo);
        run(0, x, y, 1'b1, 1'b0, es, ec, eo, 0, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder built around the one-bit full-adder cell: one sum bit per clock, LSB first, with a registered carry.
- Adds two WIDTH-bit operands plus carry-in over WIDTH cycles, trading latency for area.
- Sits between a producer and a consumer using valid/ready handshakes on both sides.
- Returns sum, carry-out and signed overflow.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- valid_i  input  1  operand request valid
- ready_o  output  1  block can accept operands
- a_i  input  WIDTH  operand A
- b_i  input  WIDTH  operand B
- cin_i  input  1  carry-in
- valid_o  output  1  result valid
- ready_i  input  1  consumer accepts result
- sum_o  output  WIDTH  A+B+Cin modulo 2^WIDTH
- cout_o  output  1  carry out of MSB
- ovf_o  output  1  signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Reset:
  - rst_n low asynchronously forces state IDLE.
  - Operand and sum shift registers, carry register and bit counter go to 0.
  - valid_o=0, sum_o=0, cout_o=0, ovf_o=0, ready_o=1.
  - Reset mid-operation abandons the operation with no output produced.
- States: IDLE, RUN, DONE.
- ready_o=1 only in IDLE. valid_o=1 only in DONE. Both are decoded from registered state.
- IDLE:
  - On valid_i&&ready_o, latch a_i and b_i into shift registers, carry<=cin_i, counter<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - s = A[0]^B[0]^carry.
  - carry <= A[0]&B[0] | carry&(A[0]^B[0]).
  - Shift A and B right by 1.
  - Shift s into the MSB of the sum register (sum register shifts right).
  - Counter increments.
  - On the cycle the counter equals WIDTH-1, capture the incoming carry as carry_msb_in, then go to DONE.
- Counter width: clog2(WIDTH); no wrap occurs, since it is cleared on load.
- Latency: valid_o rises exactly WIDTH cycles after the accepting clock edge.
- DONE:
  - sum_o holds the sum, cout_o holds the final carry, ovf_o = carry_msb_in ^ cout_o.
  - All three are stable while valid_o=1.
  - On valid_o&&ready_i, go to IDLE. Outputs keep their last values; they are meaningful only while valid_o=1.
- Throughput: at most one operation per WIDTH+2 cycles (the IDLE accept cycle is mandatory).
- valid_i while not in IDLE: ignored; operands are not sampled.
- ready_i held low in DONE: stall indefinitely with outputs unchanged.
- ready_i high outside DONE: no effect.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub_i (1 bit), sampled with the operands on accept.
  - If sub_i=1, B is latched inverted and carry is preset to 1 (cin_i ignored), giving A-B.
  - cout_o=1 means no borrow. ovf_o is the signed-subtraction overflow.
  - If sub_i=0, behaviour is identical to the plain add.
- Not defined: no sub_i port; add only.

Test Plan:
1. WIDTH=8, A=0x5A, B=0x3C, cin=0, ready_i=1 -> valid_o exactly 8 cycles after accept; sum=0x96, cout=0, ovf=1.
2. WIDTH=8, A=0xFF, B=0x01, cin=0; then A=0xFF, B=0xFF, cin=1 -> sum=0x00, cout=1, ovf=0; then sum=0xFF, cout=1, ovf=0.
3. Backpressure: hold ready_i=0 for 5 cycles in DONE; pulse valid_i with new operands during RUN and DONE -> outputs unchanged through the stall; new operands not accepted; ready_o=0 until the cycle after the result handshake.
4. Reset mid-RUN: assert rst_n low 3 cycles after accept -> immediately valid_o=0, ready_o=1, sum_o=0; next operation 0x01+0x02 gives 0x03.
5. WIDTH=4, all 512 A/B/cin combinations -> sum, cout, ovf match the reference model; WIDTH=2 and WIDTH=64 random operations also match.
6. SERIAL_ADDER_SUB_EN, WIDTH=8: sub_i=1, A=0x10, B=0x20 -> sum=0xF0, cout=0, ovf=0; A=0x80, B=0x01 -> sum=0x7F, cout=1, ovf=1.
